johnson_monitor: RTL
====================

// Module: johnson_monitor
// PURPOSE
//   Downstream checker for the 4-bit Johnson counter output.
//   - Samples the counter bus and decodes it to a binary phase.
//   - Flags illegal codes and out-of-sequence steps.
//   - Acquires and tracks lock with a small FSM.
//   - Keeps a saturating error count.
//   Sits between the Johnson counter and the tester; gives the bench a self-checking pass/fail view.
// PARAMETERS
//   WIDTH       4  Johnson register width; sequence length N = 2*WIDTH
//   LOCK_COUNT  4  consecutive correct steps needed to enter LOCKED
//   ERR_W       8  width of err_count
// PORTS
//   clk        in   1                single clock, rising edge
//   rst        in   1                synchronous, active-high reset
//   en         in   1                sample enable; jc_in is examined only when en=1
//   jc_in      in   WIDTH            Johnson counter output under check
//   clr_err    in   1                synchronous clear of err_count
//   phase      out  $clog2(2*WIDTH)  decoded phase 0..N-1 of last legal sample
//   valid_code out  1                last sample was a legal Johnson code
//   locked     out  1                FSM is in LOCKED
//   step_err   out  1                1-cycle pulse: sequence error detected
//   wrap       out  1                1-cycle pulse: correct step N-1 -> 0
//   err_count  out  ERR_W            saturating error count
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): all outputs 0; FSM=HUNT; run counter=0; have_prev=0. Takes priority over every other input, including mid-lock.
//   - Legal codes (WIDTH=4), in sequence: 0000,0001,0011,0111,1111,1110,1100,1000 = phase 0..7.
//   - Decode: pc = popcount(jc_in); phase = msb ? N-pc : pc. Legal iff jc_in equals the decoded code's pattern.
//   - Latency: all outputs registered; the update from an en=1 sample is visible 1 cycle later.
//   - en=0: all state holds; step_err and wrap are 0.
//   - Classification of each en=1 sample, given prev = registered phase:
//       ILLEGAL: illegal code. valid_code=0; phase holds.
//       FIRST:   legal code with have_prev=0. Sets the reference; have_prev=1; run=0; no error.
//       HOLD:    legal code with phase==prev. No error; run unchanged.
//       STEP:    legal code with phase==(prev+1) mod N. run=min(run+1,LOCK_COUNT); wrap=1 if prev==N-1.
//       SKIP:    any other legal code. phase updates; run=0.
//   - FSM:
//       HUNT -> LOCKED when a STEP makes run reach LOCK_COUNT.
//       HUNT: ILLEGAL or SKIP sets run=0. No step_err and no count.
//       LOCKED -> HUNT on ILLEGAL or SKIP. step_err=1 for 1 cycle; err_count+1; run=0.
//   - err_count: saturates at 2^ERR_W-1, no wrap.
//   - clr_err: sets err_count=0. If an error occurs in the same cycle, the result is 1 (clear, then count).
//   - wrap: fires in HUNT or LOCKED.
// CONFIGURATION
//   JOHNSON_MON_STATS_EN defined:
//     - Adds port rev_count out 16: count of wrap pulses while locked=1.
//     - Saturates at 16'hFFFF; cleared by rst and by clr_err.
//   Not defined: port and counter absent; all other behaviour identical.
// TESTING
//   1 rst; en=1; feed 0000,0001,0011,0111,1111 -> locked=1 one cycle after 1111; phase=4; err_count=0.
//   2 Continue 1110,1100,1000,0000 -> wrap=1 exactly one cycle after 0000; phase=0; locked stays 1.
//   3 Locked at 0011, feed 0101 -> valid_code=0; step_err pulse; err_count=1; locked=0; phase=2.
//   4 Locked at 0001, feed 0111 -> step_err pulse; err_count+1; HUNT; phase=3. Re-lock after 4 correct steps.
//   5 Locked, repeat 0111 x3 with en gaps -> no step_err; locked=1.
//     ERR_W=2 with 5 errors -> err_count=3. clr_err coincident with an error -> err_count=1.
//   6 rst asserted while locked -> next cycle all outputs 0. First sample after reset sets FIRST with no error.

Source files
------------

// File: rtl/johnson_monitor.sv
// ---------------------------------------------------------------------------
// johnson_monitor
//   Checker for a WIDTH-bit Johnson counter bus. Each enabled sample is
//   decoded to a phase 0..2*WIDTH-1 and classified as illegal, first,
//   hold, step or skip. A two-state FSM (HUNT/LOCKED) tracks lock.
//   Sequence errors are only reported and counted while locked. The error
//   counter saturates instead of wrapping.
//
//   Optional feature: define JOHNSON_MON_STATS_EN to add rev_count, a
//   saturating count of wrap pulses that occur while locked.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (highest priority)
//   en         in   sample enable for jc_in
//   jc_in      in   [WIDTH-1:0] Johnson code under check
//   clr_err    in   synchronous clear of err_count (and rev_count)
//   phase      out  decoded phase of the last legal sample
//   valid_code out  last enabled sample was a legal code
//   locked     out  FSM is in LOCKED
//   step_err   out  one-cycle pulse on a sequence error while locked
//   wrap       out  one-cycle pulse on a correct step from N-1 to 0
//   err_count  out  [ERR_W-1:0] saturating error count
//   rev_count  out  [15:0] locked wrap count (JOHNSON_MON_STATS_EN only)
// ---------------------------------------------------------------------------
module johnson_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [WIDTH-1:0]              jc_in,
  input  logic                          clr_err,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic                          valid_code,
  output logic                          locked,
  output logic                          step_err,
  output logic                          wrap,
  output logic [ERR_W-1:0]              err_count
`ifdef JOHNSON_MON_STATS_EN
  ,
  output logic [15:0]                   rev_count
`endif
);

  localparam int unsigned N   = 2 * WIDTH;
  localparam int unsigned PW  = $clog2(N);
  localparam int unsigned PCW = $clog2(WIDTH + 1);
  localparam int unsigned RW  = $clog2(LOCK_COUNT + 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [PCW-1:0]   pc;
  logic [WIDTH-1:0] pattern;
  logic [PW-1:0]    dec_phase;
  logic             dec_legal;
  logic [PW-1:0]    phase_inc;

  logic             have_prev, have_prev_d;
  logic [RW-1:0]    run, run_d;
  logic [PW-1:0]    phase_d;
  logic             valid_d;
  logic             wrap_d;
  logic             err_hit;
  logic [ERR_W-1:0] err_base, err_d;

  // Decode: the popcount gives the phase; msb selects the falling half.
  // The code is legal only if it matches the ideal pattern for that phase
  // (a contiguous run of ones anchored at bit 0 or at the msb).
  always_comb begin
    pc      = '0;
    pattern = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pc = pc + PCW'(jc_in[i]);
    end
    if (jc_in[WIDTH-1]) begin
      dec_phase = PW'(N - 32'(pc));
    end else begin
      dec_phase = PW'(pc);
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (jc_in[WIDTH-1]) begin
        pattern[i] = ((i + 32'(pc)) >= WIDTH);
      end else begin
        pattern[i] = (i < 32'(pc));
      end
    end
    dec_legal = (pattern == jc_in);
  end

  assign phase_inc = (phase == PW'(N - 1)) ? '0 : phase + 1'b1;

  // Next-state / classification
  always_comb begin
    state_d     = state_q;
    phase_d     = phase;
    valid_d     = valid_code;
    have_prev_d = have_prev;
    run_d       = run;
    wrap_d      = 1'b0;
    err_hit     = 1'b0;
    if (en) begin
      if (!dec_legal) begin
        valid_d = 1'b0;
        run_d   = '0;
        if (state_q == LOCKED) begin
          err_hit = 1'b1;
          state_d = HUNT;
        end
      end else begin
        valid_d = 1'b1;
        phase_d = dec_phase;
        if (!have_prev) begin
          have_prev_d = 1'b1;
          run_d       = '0;
        end else if (dec_phase == phase) begin
          run_d = run;
        end else if (dec_phase == phase_inc) begin
          run_d  = (run >= RW'(LOCK_COUNT)) ? RW'(LOCK_COUNT) : run + 1'b1;
          wrap_d = (phase == PW'(N - 1));
          if ((state_q == HUNT) && (run_d == RW'(LOCK_COUNT))) begin
            state_d = LOCKED;
          end
        end else begin
          run_d = '0;
          if (state_q == LOCKED) begin
            err_hit = 1'b1;
            state_d = HUNT;
          end
        end
      end
    end
  end

  // Clear first, then count, so a coincident clear and error yields 1.
  always_comb begin
    err_base = clr_err ? '0 : err_count;
    err_d    = (err_hit && (err_base != '1)) ? err_base + 1'b1 : err_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      phase      <= '0;
      valid_code <= 1'b0;
      have_prev  <= 1'b0;
      run        <= '0;
      step_err   <= 1'b0;
      wrap       <= 1'b0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      phase      <= phase_d;
      valid_code <= valid_d;
      have_prev  <= have_prev_d;
      run        <= run_d;
      step_err   <= err_hit;
      wrap       <= wrap_d;
      err_count  <= err_d;
    end
  end

  assign locked = (state_q == LOCKED);

`ifdef JOHNSON_MON_STATS_EN
  logic [15:0] rev_base, rev_d;

  // Counted against the next state so the increment lines up with the
  // visible wrap pulse and the locked flag shown alongside it.
  always_comb begin
    rev_base = clr_err ? '0 : rev_count;
    rev_d    = (wrap_d && (state_d == LOCKED) && (rev_base != 16'hFFFF)) ?
               rev_base + 16'd1 : rev_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rev_count <= '0;
    end else begin
      rev_count <= rev_d;
    end
  end
`endif

endmodule
